seq_pattern_detector: RTL and testbench
=======================================

# seq_pattern_detector

Parametrised serial bit-pattern detector: the next generation of the team's fixed single-pattern Mealy detector. Samples a 1-bit serial stream, asserts a Mealy match output in the same cycle the final pattern bit arrives, and counts matches. Pattern, length and overlap mode are runtime-configurable. Reset defaults reproduce legacy "101", overlapping detection. Sits between a serial line front-end and the event/interrupt logic.

## Interface
- PAT_W, 8: maximum pattern length in bits, ≥2.
- CNT_W, 16: match counter width.
- RST_PAT, 'b101: pattern after reset, zero-extended to PAT_W.
- RST_LEN, 3: pattern length after reset, 1..PAT_W.
- RST_OVL, 1: overlap mode after reset.

Ports:
- clk  in  1  single clock, rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- in_valid  in  1  x is a valid stream bit this cycle.
- x  in  1  serial data bit.
- cfg_load  in  1  load configuration this cycle.
- cfg_pattern  in  PAT_W  new pattern. Bit [len-1] is the oldest bit; bit [0] is the newest bit.
- cfg_len  in  $clog2(PAT_W+1)  new length.
- cfg_overlap  in  1  1 = overlapping matches, 0 = non-overlapping.
- cnt_clr  in  1  synchronous clear of match_cnt.
- z  out  1  Mealy match, combinational, same cycle.
- match_q  out  1  z registered one cycle later.
- match_cnt  out  CNT_W  saturating match count.

## Operation
- Registered state:
  - pat_r, len_r, ovl_r: active configuration.
  - hist: PAT_W-1 most recent valid bits.
  - fill: number of valid bits accumulated, 0..PAT_W-1, saturating.
  - match_q, match_cnt.
- Reset (async assert):
  - pat_r=RST_PAT, len_r=RST_LEN, ovl_r=RST_OVL.
  - hist=0, fill=0, match_q=0, match_cnt=0.
  - z=0, since fill=0 and len ≥ 2; if RST_LEN=1, z follows in_valid&x.
- Length clamp on load: cfg_len=0 loads 1; cfg_len>PAT_W loads PAT_W.
- Match condition:
  - z = in_valid & !cfg_load & fill ≥ len_r-1 & ({hist,x} masked to low len_r bits == pat_r masked to low len_r bits).
- Valid cycle without cfg_load:
  - hist shifts left, x enters at bit 0.
  - If z and !ovl_r: fill := 0.
  - Otherwise: fill := min(fill+1, PAT_W-1).
- in_valid=0: hist, fill and match_q hold; z=0.
- cfg_load (highest priority after reset):
  - Loads the configuration.
  - Clears hist and fill.
  - x ignored, z=0 that cycle.
  - match_cnt is unaffected.
- match_cnt:
  - Increments on z; saturates at 2^CNT_W-1.
  - cnt_clr alone sets it to 0.
  - cnt_clr and z in the same cycle set it to 1.

## Timing
- z is zero-latency Mealy: combinational from x, in_valid and cfg_load.
- match_q and match_cnt update at the rising edge that ends the z cycle.
- match_q is 1 for exactly one valid cycle per match. It is cleared by any cycle with z=0 and in_valid=1, or by cfg_load. It holds during bubbles.
- Reset mid-stream: all state clears immediately (async). First post-reset valid bit is treated as stream bit 1.
- Deassertion of aresetn is synchronised externally. The block requires no recovery cycles.

## Structure
- Package seq_det_pkg:
  - localparam function for the length-mask calculation.
  - Type aliases for the configuration struct (pattern, len, overlap).
- Sub-module seq_det_sat_counter: parametrised CNT_W saturating counter with inc and clr inputs, where clr and inc in the same cycle give 1. Instantiated once for match_cnt.
- Top level contains the shift history, fill counter, compare/mask logic and config registers.

## Test plan
- Defaults: valid stream 1,0,1,0,1 → z=1 on bits 3 and 5 only; match_cnt=2; match_q high on the cycles after bits 3 and 5.
- cfg_load pattern 'b101, len 3, overlap 0, then stream 1,0,1,0,1 → z only on bit 3; match_cnt=1.
- cfg_load pattern 'b1101, len 4, overlap 1, then stream 1,1,0,1,1,0,1 → z on bits 4 and 7. Insert in_valid=0 bubbles between bits → identical match positions, z=0 during bubbles.
- CNT_W=2 build, defaults, stream (10)×6 then 1 → six matches, match_cnt saturates at 3. cnt_clr asserted on a match cycle → match_cnt=1.
- After bits 1,0 of "101": cfg_load with the same config → subsequent 1 gives z=0; a further 0,1 gives a match. cfg_len=0 loads len 1 → every valid x matching pat_r[0] asserts z.
- aresetn pulsed low after bits 1,0 → all outputs 0 immediately; next bit 1 gives z=0.

Source files
------------

// File: rtl/seq_det_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_pkg
// Shared types and helpers for the serial pattern detector.
//   - pat_t / len_t        : widest pattern and length containers
//   - seq_det_cfg_t        : active configuration (pattern, length, overlap)
//   - len_mask()           : low-'len' bit mask used by the compare logic
// -----------------------------------------------------------------------------
package seq_det_pkg;

   localparam int unsigned MAX_PAT_W = 64;
   localparam int unsigned MAX_LEN_W = 7;

   typedef logic [MAX_PAT_W-1:0] pat_t;
   typedef logic [MAX_LEN_W-1:0] len_t;

   typedef struct packed {
      pat_t pattern;
      len_t len;
      logic overlap;
   } seq_det_cfg_t;

   // Bit i of the mask is set for every i below len; built bit by bit so
   // len == MAX_PAT_W never overflows a shift.
   function automatic pat_t len_mask(input len_t len);
      pat_t mask;
      mask = {MAX_PAT_W{1'b0}};
      for (int i = 0; i < MAX_PAT_W; i++) begin
         mask[i] = (len_t'(i) < len);
      end
      return mask;
   endfunction

endpackage : seq_det_pkg

// File: rtl/seq_det_sat_counter.sv
// -----------------------------------------------------------------------------
// seq_det_sat_counter
// Saturating up-counter with synchronous clear. Clear and increment in the
// same cycle leave the counter at 1 (the clearing cycle's event still counts).
// Ports:
//   clk_i   clock, rising edge
//   rst_ni  asynchronous active-low reset
//   inc_i   count one event
//   clr_i   synchronous clear
//   cnt_o   registered count, saturates at all-ones
// -----------------------------------------------------------------------------
module seq_det_sat_counter
   import seq_det_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] cnt_o
);

   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear wins over increment, increment stops at the ceiling.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = inc_i ? CNT_ONE : CNT_ZERO;
      end else if (inc_i && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_ONE;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= CNT_ZERO;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule : seq_det_sat_counter

// File: rtl/seq_pattern_detector.sv
// -----------------------------------------------------------------------------
// seq_pattern_detector
// Runtime-configurable serial bit-pattern detector with a Mealy match output.
// Ports:
//   clk          clock, rising edge
//   aresetn      asynchronous active-low reset
//   in_valid     x carries a stream bit this cycle
//   x            serial data bit
//   cfg_load     load cfg_pattern/cfg_len/cfg_overlap, clears history
//   cfg_pattern  pattern, bit [len-1] oldest, bit [0] newest
//   cfg_len      pattern length (0 -> 1, above PAT_W -> PAT_W)
//   cfg_overlap  1 = overlapping matches, 0 = restart after a match
//   cnt_clr      synchronous clear of match_cnt
//   z            combinational match in the cycle of the last pattern bit
//   match_q      z registered on valid/load cycles, holds across bubbles
//   match_cnt    saturating match count
// -----------------------------------------------------------------------------
module seq_pattern_detector
   import seq_det_pkg::*;
#(
   parameter int unsigned          PAT_W   = 8,
   parameter int unsigned          CNT_W   = 16,
   parameter logic [PAT_W-1:0]     RST_PAT = PAT_W'(3'b101),
   parameter int unsigned          RST_LEN = 3,
   parameter logic                 RST_OVL = 1'b1
) (
   input  logic                       clk,
   input  logic                       aresetn,
   input  logic                       in_valid,
   input  logic                       x,
   input  logic                       cfg_load,
   input  logic [PAT_W-1:0]           cfg_pattern,
   input  logic [$clog2(PAT_W+1)-1:0] cfg_len,
   input  logic                       cfg_overlap,
   input  logic                       cnt_clr,
   output logic                       z,
   output logic                       match_q,
   output logic [CNT_W-1:0]           match_cnt
);

   localparam int unsigned LW = $clog2(PAT_W + 1);
   localparam int unsigned FW = $clog2(PAT_W);

   localparam logic [LW-1:0] LEN_MAX  = LW'(PAT_W);
   localparam logic [LW-1:0] LEN_ZERO = {LW{1'b0}};
   localparam logic [LW-1:0] LEN_ONE  = LW'(1'b1);
   localparam logic [FW-1:0] FILL_MAX = FW'(PAT_W - 1);
   localparam logic [FW-1:0] FILL_ONE = FW'(1'b1);

   localparam seq_det_cfg_t CFG_RST = '{
      pattern: pat_t'(RST_PAT),
      len:     len_t'(RST_LEN),
      overlap: RST_OVL
   };

   seq_det_cfg_t     cfg_q,   cfg_d;
   logic [PAT_W-2:0] hist_q,  hist_d;
   logic [FW-1:0]    fill_q,  fill_d;
   logic             match_d;

   logic [PAT_W-1:0] shift_s;
   logic [LW-1:0]    len_clamp_s;
   logic             fill_ok_s;
   logic             eq_s;
   logic             z_s;

   // History plus the incoming bit forms the compare window and the next history.
   assign shift_s = {hist_q, x};

   // Enough bits seen since the last restart to complete a pattern of len_r bits.
   assign fill_ok_s = (len_t'(fill_q) >= (cfg_q.len - len_t'(1'b1)));

   // Window and pattern agree on every bit inside the active length.
   assign eq_s = (((pat_t'(shift_s) ^ cfg_q.pattern) & len_mask(cfg_q.len)) == {MAX_PAT_W{1'b0}});

   assign z_s = in_valid & ~cfg_load & fill_ok_s & eq_s;
   assign z   = z_s;

   // Length clamp applied to a configuration load.
   always_comb begin
      len_clamp_s = cfg_len;
      if (cfg_len == LEN_ZERO) begin
         len_clamp_s = LEN_ONE;
      end else if (cfg_len > LEN_MAX) begin
         len_clamp_s = LEN_MAX;
      end else begin
         len_clamp_s = cfg_len;
      end
   end

   // Next state: config load first, then valid stream bits, bubbles hold.
   always_comb begin
      cfg_d   = cfg_q;
      hist_d  = hist_q;
      fill_d  = fill_q;
      match_d = match_q;
      if (cfg_load) begin
         cfg_d.pattern = pat_t'(cfg_pattern);
         cfg_d.len     = len_t'(len_clamp_s);
         cfg_d.overlap = cfg_overlap;
         hist_d        = {(PAT_W-1){1'b0}};
         fill_d        = {FW{1'b0}};
         match_d       = 1'b0;
      end else if (in_valid) begin
         hist_d  = shift_s[PAT_W-2:0];
         match_d = z_s;
         // A non-overlapping match restarts accumulation; history still shifts.
         if (z_s && !cfg_q.overlap) begin
            fill_d = {FW{1'b0}};
         end else if (fill_q == FILL_MAX) begin
            fill_d = fill_q;
         end else begin
            fill_d = fill_q + FILL_ONE;
         end
      end else begin
         hist_d  = hist_q;
         fill_d  = fill_q;
         match_d = match_q;
      end
   end

   // Configuration, history, fill and registered match.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         cfg_q   <= CFG_RST;
         hist_q  <= {(PAT_W-1){1'b0}};
         fill_q  <= {FW{1'b0}};
         match_q <= 1'b0;
      end else begin
         cfg_q   <= cfg_d;
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         match_q <= match_d;
      end
   end

   seq_det_sat_counter #(
      .CNT_W (CNT_W)
   ) u_match_cnt (
      .clk_i  (clk),
      .rst_ni (aresetn),
      .inc_i  (z_s),
      .clr_i  (cnt_clr),
      .cnt_o  (match_cnt)
   );

endmodule : seq_pattern_detector

// File: tb/tb_seq_pattern_detector.sv
// -----------------------------------------------------------------------------
// tb_seq_pattern_detector
// Directed and random stimulus against a bit-queue reference model. Two
// instances share all inputs: the default build and a CNT_W=2 build.
// -----------------------------------------------------------------------------
module tb_seq_pattern_detector;

   localparam int PAT_W = 8;

   logic       clk = 1'b0;
   logic       aresetn = 1'b0;
   logic       in_valid = 1'b0;
   logic       x = 1'b0;
   logic       cfg_load = 1'b0;
   logic [7:0] cfg_pattern = 8'h00;
   logic [3:0] cfg_len = 4'd0;
   logic       cfg_overlap = 1'b0;
   logic       cnt_clr = 1'b0;

   logic        z, match_q;
   logic [15:0] match_cnt;
   logic        z2, match_q2;
   logic [1:0]  match_cnt2;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model state
   bit       hq[$];
   int       since;
   bit [7:0] m_pat;
   int       m_len;
   bit       m_ovl;
   bit       m_mq;
   int       m_cnt;
   int       m_cnt2;

   always #5 clk = ~clk;

   seq_pattern_detector u_dut (
      .clk(clk), .aresetn(aresetn), .in_valid(in_valid), .x(x),
      .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
      .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
      .z(z), .match_q(match_q), .match_cnt(match_cnt)
   );

   seq_pattern_detector #(.CNT_W(2)) u_dut2 (
      .clk(clk), .aresetn(aresetn), .in_valid(in_valid), .x(x),
      .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
      .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
      .z(z2), .match_q(match_q2), .match_cnt(match_cnt2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      hq.delete();
      since  = 0;
      m_pat  = 8'b0000_0101;
      m_len  = 3;
      m_ovl  = 1'b1;
      m_mq   = 1'b0;
      m_cnt  = 0;
      m_cnt2 = 0;
   endtask

   // Match = the last m_len stream bits (newest = x) equal pattern bits [m_len-1:0].
   function automatic bit model_z(input bit v, input bit xb, input bit ld);
      if (!v || ld) return 1'b0;
      if (since < m_len - 1) return 1'b0;
      for (int i = 0; i < m_len; i++) begin
         bit b;
         b = (i == 0) ? xb : hq[hq.size() - i];
         if (b != m_pat[i]) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic step(input bit v, input bit xb, input bit ld = 1'b0,
                       input bit [7:0] pat = 8'h00, input bit [3:0] len = 4'd0,
                       input bit ovl = 1'b0, input bit clr = 1'b0);
      bit ez;
      @(negedge clk);
      in_valid = v; x = xb; cfg_load = ld; cfg_pattern = pat;
      cfg_len = len; cfg_overlap = ovl; cnt_clr = clr;
      #1;
      ez = model_z(v, xb, ld);
      check("z", z, ez);
      check("z_cnt2", z2, ez);
      @(posedge clk);
      if (ld) begin
         m_pat = pat;
         m_len = (len == 0) ? 1 : ((len > PAT_W) ? PAT_W : int'(len));
         m_ovl = ovl;
         hq.delete();
         since = 0;
         m_mq  = 1'b0;
      end else if (v) begin
         hq.push_back(xb);
         if (hq.size() > 64) void'(hq.pop_front());
         if (ez && !m_ovl) since = 0;
         else since++;
         m_mq = ez;
      end
      if (clr) begin
         m_cnt  = ez ? 1 : 0;
         m_cnt2 = ez ? 1 : 0;
      end else if (ez) begin
         if (m_cnt < 65535) m_cnt++;
         if (m_cnt2 < 3) m_cnt2++;
      end
      #1;
      check("match_q", match_q, m_mq);
      check("match_q_cnt2", match_q2, m_mq);
      check("match_cnt", match_cnt, m_cnt);
      check("match_cnt2", match_cnt2, m_cnt2);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      in_valid = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
      aresetn = 1'b0;
      model_reset();
      #1;
      check("rst_z", z, 0);
      check("rst_match_q", match_q, 0);
      check("rst_match_cnt", match_cnt, 0);
      check("rst_match_cnt2", match_cnt2, 0);
      @(negedge clk);
      aresetn = 1'b1;
   endtask

   task automatic stream(input bit [31:0] bits, input int n, input bit bubbles = 1'b0);
      for (int i = n - 1; i >= 0; i--) begin
         step(1'b1, bits[i]);
         if (bubbles) begin
            step(1'b0, 1'b1);
            step(1'b0, 1'b0);
         end
      end
   endtask

   initial begin
      model_reset();
      pulse_reset();

      // Legacy defaults, overlapping "101"
      stream(32'b10101, 5);
      check("plan_defaults_cnt", match_cnt, 2);

      // Non-overlapping "101"
      step(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1, 8'b101, 4'd3, 1'b0);
      stream(32'b10101, 5);
      check("plan_nonovl_cnt", match_cnt, 1);

      // "1101" overlapping, then the same with bubbles
      step(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1, 8'b1101, 4'd4, 1'b1);
      stream(32'b1101101, 7);
      check("plan_1101_cnt", match_cnt, 2);
      step(1'b0, 1'b0, 1'b1, 8'b1101, 4'd4, 1'b1);
      stream(32'b1101101, 7, 1'b1);
      check("plan_1101_bubble_cnt", match_cnt, 4);

      // Saturation of the 2-bit counter, then clear on a match cycle
      step(1'b0, 1'b0, 1'b1, 8'b101, 4'd3, 1'b1, 1'b1);
      stream(32'b1010101010101, 13);
      check("plan_sat_cnt16", match_cnt, 6);
      check("plan_sat_cnt2", match_cnt2, 3);
      step(1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1);
      check("plan_clr_on_match", match_cnt2, 1);

      // Reload of the same config discards partial history
      step(1'b0, 1'b0, 1'b1, 8'b101, 4'd3, 1'b1);
      stream(32'b10, 2);
      step(1'b1, 1'b1, 1'b1, 8'b101, 4'd3, 1'b1);
      stream(32'b101, 3);

      // cfg_len = 0 loads length 1, and over-long length clamps to PAT_W
      step(1'b0, 1'b0, 1'b1, 8'h01, 4'd0, 1'b1);
      for (int i = 0; i < 10; i++) step(1'b1, 1'($urandom_range(0, 1)));
      step(1'b0, 1'b0, 1'b1, 8'hA5, 4'd15, 1'b1);
      stream(32'hA5A5, 16);

      // Asynchronous reset mid-stream
      step(1'b0, 1'b0, 1'b1, 8'b101, 4'd3, 1'b1);
      stream(32'b10, 2);
      pulse_reset();
      step(1'b1, 1'b1);

      // Random traffic with occasional reconfiguration and clears
      for (int i = 0; i < 600; i++) begin
         bit       ld, clr, v;
         bit [3:0] len;
         ld  = ($urandom_range(0, 39) == 0);
         clr = ($urandom_range(0, 29) == 0);
         v   = ($urandom_range(0, 3) != 0);
         len = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4));
         step(v, 1'($urandom_range(0, 1)), ld, 8'($urandom_range(0, 255)), len,
              1'($urandom_range(0, 1)), clr);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule : tb_seq_pattern_detector
